// File: rtl/operand_fetch_pkg.sv
// Addressing-mode codes shared by the W65C832 decode and operand fetch logic,
// plus the operand byte-count rule used when a fetch request is accepted.
package operand_fetch_pkg;

    localparam logic [3:0] MODE_NONE       = 4'd0;
    localparam logic [3:0] MODE_IMMEDIATE  = 4'd1;
    localparam logic [3:0] MODE_ZP         = 4'd2;
    localparam logic [3:0] MODE_ABSOLUTE   = 4'd3;
    localparam logic [3:0] MODE_INDEXED_X  = 4'd4;
    localparam logic [3:0] MODE_ABSOLUTE_X = 4'd5;
    localparam logic [3:0] MODE_ABSOLUTE_Y = 4'd6;
    localparam logic [3:0] MODE_INDIRECT_X = 4'd7;
    localparam logic [3:0] MODE_INDIRECT_Y = 4'd8;
    localparam logic [3:0] MODE_A          = 4'd9;

    localparam logic [2:0] MAX_OPERAND_BYTES = 3'd4;

    // NONE, A and unknown codes never touch memory, whatever extra_bytes says.
    function automatic logic [2:0] byte_count(input logic [3:0] mode,
                                              input logic [2:0] extra,
                                              input logic [2:0] imm);
        logic [2:0] n;
        case (mode)
            MODE_IMMEDIATE: n = (imm == 3'd0) ? 3'd1 : imm;
            MODE_ZP, MODE_ABSOLUTE, MODE_INDEXED_X, MODE_ABSOLUTE_X,
            MODE_ABSOLUTE_Y, MODE_INDIRECT_X, MODE_INDIRECT_Y: n = extra;
            default: n = 3'd0;
        endcase
        if (n > MAX_OPERAND_BYTES) begin
            n = MAX_OPERAND_BYTES;
        end
        return n;
    endfunction

endpackage

// File: rtl/operand_fetch_ea_calc.sv
// Combinational effective-address and indirect-pointer arithmetic (ea_calc).
// ZP_WRAP_EN selects emulation-style page-0 wrapping; undefined gives native 24-bit sums.
module ea_calc
    import operand_fetch_pkg::*;
(
    input  logic [3:0]  mode_i,
    input  logic [7:0]  b0_i,
    input  logic [7:0]  b1_i,
    input  logic [7:0]  ptr_lo_i,
    input  logic [7:0]  ptr_hi_i,
    input  logic [23:0] pc_i,
    input  logic [7:0]  data_bank_i,
    input  logic [23:0] reg_x_i,
    input  logic [23:0] reg_y_i,
    output logic [23:0] ea_o,
    output logic [23:0] ptr_addr_o,
    output logic [23:0] ptr_addr_next_o
);

    logic [23:0] abs_base;
    logic [23:0] ind_base;
    logic [23:0] zp_x;

`ifdef ZP_WRAP_EN
    logic [7:0]  zp_x_lo;
    logic [7:0]  ptr_lo_sum;
    logic [7:0]  ptr_next_lo;
    logic        unused_x_hi;

    assign unused_x_hi = ^reg_x_i[23:8];

    always_comb begin
        zp_x_lo     = b0_i + reg_x_i[7:0];
        zp_x        = {16'h0000, zp_x_lo};
        ptr_lo_sum  = (mode_i == MODE_INDIRECT_X) ? zp_x_lo : b0_i;
        ptr_next_lo = ptr_lo_sum + 8'd1;
        ptr_addr_o      = {16'h0000, ptr_lo_sum};
        ptr_addr_next_o = {16'h0000, ptr_next_lo};
    end
`else
    always_comb begin
        zp_x = {16'h0000, b0_i} + reg_x_i;
        ptr_addr_o      = (mode_i == MODE_INDIRECT_X) ? zp_x : {16'h0000, b0_i};
        ptr_addr_next_o = ptr_addr_o + 24'd1;
    end
`endif

    always_comb begin
        abs_base = {data_bank_i, b1_i, b0_i};
        ind_base = {data_bank_i, ptr_hi_i, ptr_lo_i};
        case (mode_i)
            MODE_IMMEDIATE:  ea_o = pc_i;
            MODE_ZP:         ea_o = {16'h0000, b0_i};
            MODE_ABSOLUTE:   ea_o = abs_base;
            MODE_INDEXED_X:  ea_o = zp_x;
            MODE_ABSOLUTE_X: ea_o = abs_base + reg_x_i;
            MODE_ABSOLUTE_Y: ea_o = abs_base + reg_y_i;
            MODE_INDIRECT_X: ea_o = ind_base;
            MODE_INDIRECT_Y: ea_o = ind_base + reg_y_i;
            default:         ea_o = 24'h000000;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// W65C832 operand fetcher: reads operand bytes and indirect pointers, returns operand/EA/next PC.
// Build option ZP_WRAP_EN (handled inside ea_calc) selects page-0 wrapping of indexed/pointer sums.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  mode,
    input  logic [2:0]  extra_bytes,
    input  logic [2:0]  imm_bytes,
    input  logic [23:0] pc,
    input  logic [7:0]  data_bank,
    input  logic [31:0] reg_x,
    input  logic [31:0] reg_y,
    output logic        mem_rd,
    output logic [23:0] mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] operand,
    output logic [23:0] ea,
    output logic [23:0] next_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PTR_LO,
        S_PTR_HI,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  mode_q, mode_d;
    logic [2:0]  count_q, count_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] pc_q, pc_d;
    logic [7:0]  bank_q, bank_d;
    logic [23:0] x_q, x_d;
    logic [23:0] y_q, y_d;
    logic [31:0] operand_q, operand_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic [23:0] ea_q, ea_d;
    logic [23:0] next_pc_q, next_pc_d;

    logic [2:0]  start_count;
    logic [23:0] calc_ea;
    logic [23:0] ptr_addr;
    logic [23:0] ptr_addr_next;
    logic        unused_idx_hi;

    assign unused_idx_hi = ^{reg_x[31:24], reg_y[31:24]};
    assign start_count   = byte_count(mode, extra_bytes, imm_bytes);

    ea_calc u_ea_calc (
        .mode_i          (mode_q),
        .b0_i            (operand_q[7:0]),
        .b1_i            (operand_q[15:8]),
        .ptr_lo_i        (lo_q),
        .ptr_hi_i        (hi_q),
        .pc_i            (pc_q),
        .data_bank_i     (bank_q),
        .reg_x_i         (x_q),
        .reg_y_i         (y_q),
        .ea_o            (calc_ea),
        .ptr_addr_o      (ptr_addr),
        .ptr_addr_next_o (ptr_addr_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            mode_q    <= MODE_NONE;
            count_q   <= 3'd0;
            idx_q     <= 3'd0;
            pc_q      <= 24'h0;
            bank_q    <= 8'h0;
            x_q       <= 24'h0;
            y_q       <= 24'h0;
            operand_q <= 32'h0;
            lo_q      <= 8'h0;
            hi_q      <= 8'h0;
            ea_q      <= 24'h0;
            next_pc_q <= 24'h0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            pc_q      <= pc_d;
            bank_q    <= bank_d;
            x_q       <= x_d;
            y_q       <= y_d;
            operand_q <= operand_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            ea_q      <= ea_d;
            next_pc_q <= next_pc_d;
        end
    end

    // Each read state holds mem_addr until mem_ready, then moves on the same edge.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        count_d   = count_q;
        idx_d     = idx_q;
        pc_d      = pc_q;
        bank_d    = bank_q;
        x_d       = x_q;
        y_d       = y_q;
        operand_d = operand_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        ea_d      = ea_q;
        next_pc_d = next_pc_q;
        mem_rd    = 1'b0;
        mem_addr  = 24'h0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d    = mode;
                    count_d   = start_count;
                    idx_d     = 3'd0;
                    pc_d      = pc;
                    bank_d    = data_bank;
                    x_d       = reg_x[23:0];
                    y_d       = reg_y[23:0];
                    operand_d = 32'h0;
                    lo_d      = 8'h0;
                    hi_d      = 8'h0;
                    next_pc_d = pc + {21'b0, start_count};
                    state_d   = (start_count != 3'd0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = pc_q + {21'b0, idx_q};
                if (mem_ready) begin
                    operand_d[{idx_q[1:0], 3'b000} +: 8] = mem_data;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == count_q - 3'd1) begin
                        if (mode_q == MODE_INDIRECT_X || mode_q == MODE_INDIRECT_Y) begin
                            state_d = S_PTR_LO;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_PTR_LO: begin
                mem_rd   = 1'b1;
                mem_addr = ptr_addr;
                if (mem_ready) begin
                    lo_d    = mem_data;
                    state_d = S_PTR_HI;
                end
            end
            S_PTR_HI: begin
                mem_rd   = 1'b1;
                mem_addr = ptr_addr_next;
                if (mem_ready) begin
                    hi_d    = mem_data;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ea_d    = calc_ea;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The fresh EA is visible in the DONE cycle itself, then held in ea_q.
    assign ea      = (state_q == S_DONE) ? calc_ea : ea_q;
    assign operand = operand_q;
    assign next_pc = next_pc_q;
    assign done    = (state_q == S_DONE);
    assign busy    = (state_q == S_FETCH) || (state_q == S_PTR_LO) || (state_q == S_PTR_HI);

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch with a byte-wide memory model.
// Expected values for the page-0 wrap cases follow the ZP_WRAP_EN build setting.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  mode;
    logic [2:0]  extra_bytes;
    logic [2:0]  imm_bytes;
    logic [23:0] pc;
    logic [7:0]  data_bank;
    logic [31:0] reg_x;
    logic [31:0] reg_y;
    logic        mem_rd;
    logic [23:0] mem_addr;
    logic        mem_ready;
    logic [7:0]  mem_data;
    logic        busy;
    logic        done;
    logic [31:0] operand;
    logic [23:0] ea;
    logic [23:0] next_pc;

    logic [7:0]  mem [logic [23:0]];
    logic [23:0] readLog [$];
    int          doneCount = 0;
    int          total = 0;
    int          bad = 0;

`ifdef ZP_WRAP_EN
    localparam logic [23:0] EXP_IX_EA    = 24'h000010;
    localparam logic [23:0] EXP_IY_PTRHI = 24'h000000;
    localparam logic [23:0] EXP_IY_EA    = 24'h002010;
`else
    localparam logic [23:0] EXP_IX_EA    = 24'h000110;
    localparam logic [23:0] EXP_IY_PTRHI = 24'h000100;
    localparam logic [23:0] EXP_IY_EA    = 24'h003010;
`endif

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .mode        (mode),
        .extra_bytes (extra_bytes),
        .imm_bytes   (imm_bytes),
        .pc          (pc),
        .data_bank   (data_bank),
        .reg_x       (reg_x),
        .reg_y       (reg_y),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_data    (mem_data),
        .busy        (busy),
        .done        (done),
        .operand     (operand),
        .ea          (ea),
        .next_pc     (next_pc)
    );

    always @(negedge clk) begin
        mem_data <= mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
    end

    always begin
        @(negedge clk);
        #1;
        if (mem_rd === 1'b1 && mem_ready === 1'b1) readLog.push_back(mem_addr);
        if (done === 1'b1) doneCount++;
    end

    task automatic launch(input logic [3:0] m, input logic [2:0] eb, input logic [2:0] ib,
                          input logic [23:0] p, input logic [7:0] bank,
                          input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        mode = m; extra_bytes = eb; imm_bytes = ib; pc = p;
        data_bank = bank; reg_x = x; reg_y = y;
        start = 1'b1;
        readLog.delete();
        doneCount = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int startCyc, output int doneCyc);
        int cyc = startCyc;
        while (done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        doneCyc = (done === 1'b1) ? cyc : -1;
        #2;
    endtask

    task automatic run_op(input logic [3:0] m, input logic [2:0] eb, input logic [2:0] ib,
                          input logic [23:0] p, input logic [7:0] bank,
                          input logic [31:0] x, input logic [31:0] y,
                          output int doneCyc, output logic firstRd);
        launch(m, eb, ib, p, bank, x, y);
        firstRd = mem_rd;
        wait_done(1, doneCyc);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; mode = 4'd0; extra_bytes = 3'd0; imm_bytes = 3'd0;
        pc = 24'h0; data_bank = 8'h0; reg_x = 32'h0; reg_y = 32'h0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({mem_rd, busy, done, mem_addr, operand, ea, next_pc} !== 107'h0) begin
            bad++;
            $display("FAIL reset_values: got rd=%b busy=%b done=%b addr=%h op=%h ea=%h npc=%h want all zero",
                     mem_rd, busy, done, mem_addr, operand, ea, next_pc);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_absolute();
        int dc; logic fr;
        mem.delete();
        mem[24'h001000] = 8'h34; mem[24'h001001] = 8'h12;
        run_op(MODE_ABSOLUTE, 3'd2, 3'd1, 24'h001000, 8'h02, 32'h0, 32'h0, dc, fr);
        total++;
        if (dc !== 3 || fr !== 1'b1) begin
            bad++; $display("FAIL abs_latency: got done=%0d rd1=%b want done=3 rd1=1", dc, fr);
        end
        total++;
        if (ea !== 24'h021234 || next_pc !== 24'h001002 || operand !== 32'h00001234) begin
            bad++; $display("FAIL abs_result: got ea=%h npc=%h op=%h want 021234 001002 00001234", ea, next_pc, operand);
        end
        total++;
        if (readLog.size() != 2 || readLog[0] !== 24'h001000 || readLog[1] !== 24'h001001) begin
            bad++; $display("FAIL abs_reads: got %0d reads want 2 at 001000,001001", readLog.size());
        end
        // start during the DONE cycle must be ignored
        mode = MODE_A; pc = 24'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || ea !== 24'h021234 || next_pc !== 24'h001002) begin
            bad++; $display("FAIL start_in_done: got done=%b busy=%b ea=%h npc=%h want 0 0 021234 001002", done, busy, ea, next_pc);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || ea !== 24'h021234) begin
            bad++; $display("FAIL hold_after_done: got done=%b ea=%h want 0 021234", done, ea);
        end
    endtask

    task automatic test_indirect_y();
        int dc; logic fr;
        mem.delete();
        mem[24'h002000] = 8'hFF; mem[24'h0000FF] = 8'h00;
        mem[24'h000000] = 8'h20; mem[24'h000100] = 8'h30;
        run_op(MODE_INDIRECT_Y, 3'd1, 3'd1, 24'h002000, 8'h00, 32'h0, 32'h10, dc, fr);
        total++;
        if (dc !== 4) begin
            bad++; $display("FAIL indy_latency: got done=%0d want 4", dc);
        end
        total++;
        if (ea !== EXP_IY_EA || next_pc !== 24'h002001) begin
            bad++; $display("FAIL indy_ea: got ea=%h npc=%h want %h 002001", ea, next_pc, EXP_IY_EA);
        end
        total++;
        if (readLog.size() != 3 || readLog[1] !== 24'h0000FF || readLog[2] !== EXP_IY_PTRHI) begin
            bad++; $display("FAIL indy_ptr_reads: got %0d reads want 3 with ptr 0000FF,%h", readLog.size(), EXP_IY_PTRHI);
        end
    endtask

    task automatic test_indexed_x();
        int dc; logic fr;
        mem.delete();
        mem[24'h003000] = 8'hF0;
        run_op(MODE_INDEXED_X, 3'd1, 3'd1, 24'h003000, 8'h05, 32'h20, 32'h0, dc, fr);
        total++;
        if (dc !== 2 || ea !== EXP_IX_EA || next_pc !== 24'h003001) begin
            bad++; $display("FAIL idx_x_wrap: got done=%0d ea=%h npc=%h want 2 %h 003001", dc, ea, next_pc, EXP_IX_EA);
        end
    endtask

    task automatic test_immediate();
        int dc; logic fr;
        mem.delete();
        mem[24'h005000] = 8'h78; mem[24'h005001] = 8'h56;
        mem[24'h005002] = 8'h34; mem[24'h005003] = 8'h12;
        mem[24'h005010] = 8'hAB;
        run_op(MODE_IMMEDIATE, 3'd0, 3'd4, 24'h005000, 8'h09, 32'h0, 32'h0, dc, fr);
        total++;
        if (dc !== 5 || operand !== 32'h12345678 || ea !== 24'h005000 || next_pc !== 24'h005004) begin
            bad++; $display("FAIL imm4: got done=%0d op=%h ea=%h npc=%h want 5 12345678 005000 005004", dc, operand, ea, next_pc);
        end
        run_op(MODE_IMMEDIATE, 3'd3, 3'd0, 24'h005010, 8'h09, 32'h0, 32'h0, dc, fr);
        total++;
        if (dc !== 2 || operand !== 32'h000000AB || next_pc !== 24'h005011) begin
            bad++; $display("FAIL imm0_as_1: got done=%0d op=%h npc=%h want 2 000000ab 005011", dc, operand, next_pc);
        end
    endtask

    task automatic test_clamp();
        int dc; logic fr;
        mem.delete();
        mem[24'h006000] = 8'h01; mem[24'h006001] = 8'h02;
        mem[24'h006002] = 8'h03; mem[24'h006003] = 8'h04;
        run_op(MODE_ABSOLUTE, 3'd7, 3'd1, 24'h006000, 8'h07, 32'h0, 32'h0, dc, fr);
        total++;
        if (dc !== 5 || operand !== 32'h04030201 || ea !== 24'h070201 || next_pc !== 24'h006004) begin
            bad++; $display("FAIL clamp4: got done=%0d op=%h ea=%h npc=%h want 5 04030201 070201 006004", dc, operand, ea, next_pc);
        end
    endtask

    task automatic test_mode_a();
        int dc; logic fr;
        run_op(MODE_A, 3'd2, 3'd1, 24'h007000, 8'h01, 32'h0, 32'h0, dc, fr);
        total++;
        if (dc !== 1 || fr !== 1'b0 || readLog.size() != 0 || ea !== 24'h0 || next_pc !== 24'h007000) begin
            bad++; $display("FAIL mode_a: got done=%0d rd=%b reads=%0d ea=%h npc=%h want 1 0 0 000000 007000",
                            dc, fr, readLog.size(), ea, next_pc);
        end
        run_op(4'hF, 3'd2, 3'd1, 24'h007100, 8'h01, 32'h0, 32'h0, dc, fr);
        total++;
        if (dc !== 1 || readLog.size() != 0 || ea !== 24'h0) begin
            bad++; $display("FAIL unknown_mode: got done=%0d reads=%0d ea=%h want 1 0 000000", dc, readLog.size(), ea);
        end
    endtask

    task automatic test_stall_ignored_start();
        int dc;
        logic addrOk = 1'b1;
        logic busyOk = 1'b1;
        mem.delete();
        mem[24'h001000] = 8'h34; mem[24'h001001] = 8'h12;
        mem_ready = 1'b0;
        launch(MODE_ABSOLUTE, 3'd2, 3'd1, 24'h001000, 8'h02, 32'h0, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            if (mem_addr !== 24'h001000 || mem_rd !== 1'b1) addrOk = 1'b0;
            if (busy !== 1'b1) busyOk = 1'b0;
            if (k == 2) begin
                start = 1'b1; mode = MODE_A; pc = 24'h009999;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        mem_ready = 1'b1;
        if (mem_addr !== 24'h001000) addrOk = 1'b0;
        total++;
        if (addrOk !== 1'b1 || busyOk !== 1'b1) begin
            bad++; $display("FAIL stall_hold: got addr_stable=%b busy=%b want 1 1", addrOk, busyOk);
        end
        wait_done(4, dc);
        total++;
        if (dc !== 6 || ea !== 24'h021234 || next_pc !== 24'h001002) begin
            bad++; $display("FAIL stall_result: got done=%0d ea=%h npc=%h want 6 021234 001002", dc, ea, next_pc);
        end
        total++;
        if (readLog.size() != 2 || readLog[0] !== 24'h001000 || readLog[1] !== 24'h001001) begin
            bad++; $display("FAIL stall_reads: got %0d completed reads want 2", readLog.size());
        end
        repeat (3) @(negedge clk);
        #2;
        total++;
        if (doneCount != 1 || busy !== 1'b0) begin
            bad++; $display("FAIL ignored_start: got done_pulses=%0d busy=%b want 1 0", doneCount, busy);
        end
    endtask

    task automatic test_reset_mid();
        int dc; logic fr;
        mem.delete();
        mem[24'h004000] = 8'h40; mem[24'h000045] = 8'h11; mem[24'h000046] = 8'h22;
        launch(MODE_INDIRECT_X, 3'd1, 3'd1, 24'h004000, 8'h03, 32'h05, 32'h0);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total++;
        if (mem_rd !== 1'b1 || mem_addr !== 24'h000046) begin
            bad++; $display("FAIL indx_ptr_hi_addr: got rd=%b addr=%h want 1 000046", mem_rd, mem_addr);
        end
        #1;
        reset_n = 1'b0;
        #1;
        total++;
        if ({mem_rd, busy, done, mem_addr, operand, ea, next_pc} !== 107'h0) begin
            bad++; $display("FAIL reset_mid: got rd=%b busy=%b done=%b addr=%h op=%h ea=%h npc=%h want all zero",
                            mem_rd, busy, done, mem_addr, operand, ea, next_pc);
        end
        repeat (3) @(negedge clk);
        #2;
        total++;
        if (doneCount != 0) begin
            bad++; $display("FAIL reset_no_done: got %0d done pulses want 0", doneCount);
        end
        reset_n = 1'b1;
        mem_ready = 1'b1;
        mem[24'h001000] = 8'h34; mem[24'h001001] = 8'h12;
        run_op(MODE_ABSOLUTE, 3'd2, 3'd1, 24'h001000, 8'h02, 32'h0, 32'h0, dc, fr);
        total++;
        if (dc !== 3 || ea !== 24'h021234 || next_pc !== 24'h001002) begin
            bad++; $display("FAIL after_reset: got done=%0d ea=%h npc=%h want 3 021234 001002", dc, ea, next_pc);
        end
    endtask

    initial begin
        test_reset();
        test_absolute();
        test_indirect_y();
        test_indexed_x();
        test_immediate();
        test_clamp();
        test_mode_a();
        test_stall_ignored_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
